approx_err_accum: RTL and testbench
===================================

Name: approx_err_accum

Overview:
- Downstream consumer of the 32x32 signed approximate multiplier.
- Accepts a stream of (approximate, exact) 64-bit signed product pairs through a valid/ready handshake.
- Over a programmed number of samples it accumulates error statistics: error count, sum of absolute error distance (for MED), and maximum absolute error distance.
- Replaces offline post-processing of dumped products with on-chip characterisation.

Parameters:
- P_W, 64, product width in bits; both inputs are two's-complement signed.
- CNT_W, 20, sample counter width; supports up to 2^CNT_W - 1 samples per run.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a run (honoured in IDLE or DONE only)
- num_samples  input  CNT_W  samples per run; sampled on accepted start
- in_valid  input  1  approx/exact pair valid
- in_ready  output  1  block can accept a pair this cycle
- approx  input  P_W  approximate product (signed)
- exact  input  P_W  exact product (signed)
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE; statistics stable
- sample_cnt  output  CNT_W  pairs accepted this run
- err_cnt  output  CNT_W  pairs with approx != exact
- sum_ed  output  P_W+CNT_W  sum of |approx - exact|
- max_ed  output  P_W  maximum |approx - exact| this run

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs go to 0, including in_ready, busy and done.
  - The pipeline valid bits clear.
- Reset mid-run: the run is abandoned and no partial result is kept.
- State IDLE:
  - On start, latch num_samples into n_tgt and clear all statistics and sample_cnt.
  - If n_tgt == 0, go to DONE; otherwise go to RUN.
- State RUN:
  - in_ready = 1 while sample_cnt < n_tgt.
  - A pair transfers when in_valid and in_ready are both 1; sample_cnt increments on each transfer.
  - On the transfer that makes sample_cnt == n_tgt, go to DRAIN. in_ready is 0 from the next cycle.
- State DRAIN: wait until both pipeline stages are empty, then go to DONE.
- State DONE:
  - done = 1 and all statistics are held.
  - start clears the statistics and re-enters RUN (or DONE if num_samples == 0).
  - There is no automatic return to IDLE.
- start in RUN or DRAIN is ignored.
- Datapath, two pipeline stages, each with its own valid bit:
  - S1 registers diff = sign-extended approx minus sign-extended exact, computed at P_W+1 bits (no overflow).
  - S2 registers ed = |diff| truncated to P_W bits unsigned. This is lossless because max |diff| = 2^P_W - 1.
  - S2 also registers ne = (diff != 0).
  - Accumulate stage: when S2 is valid, sum_ed += ed, err_cnt += ne, and max_ed updates to ed if ed > max_ed.
- Latency:
  - The statistics include a pair 3 cycles after its transfer edge.
  - done rises no later than 3 cycles after the last transfer.
- Overflow: sum_ed cannot overflow for n <= 2^CNT_W - 1; no saturation logic is needed.
- in_valid while in_ready = 0 is ignored; no data is consumed.
- approx and exact need only be stable in the transfer cycle.
- Back-to-back transfers every cycle are supported with no bubbles.
- in_valid gaps stall only the input; in-flight pairs continue through the pipeline.

Test Plan:
- Reset mid-run: rst pulse after 3 transfers -> all outputs 0 asynchronously, state IDLE, in_ready = 0.
- Exact match: num_samples=4, four pairs with approx=exact=0x0000000000001234 -> done, err_cnt=0, sum_ed=0, max_ed=0, sample_cnt=4.
- Signed errors: num_samples=3, pairs (approx,exact) = (10,7), (-5,3), (-8,-8) -> err_cnt=2, sum_ed=11, max_ed=8.
- Extreme span: approx=0x7FFFFFFFFFFFFFFF, exact=0x8000000000000000, num_samples=1 -> max_ed=sum_ed=0xFFFFFFFFFFFFFFFF, err_cnt=1.
- Handshake and drain:
  - num_samples=5 with in_valid toggling 1,0,1,1,0,1,1.
  - Required: exactly 5 transfers, and in_ready drops the cycle after the 5th.
  - done rises <=3 cycles after the 5th transfer; a 6th pair offered after that is not counted.
- Restart and zero count:
  - In DONE, start with num_samples=0 -> statistics cleared and done reasserted the next cycle.
  - start asserted during RUN -> ignored; statistics unaffected.

Source files
------------

// File: rtl/approx_err_accum.sv
`default_nettype none
// ============================================================================
// Module      : approx_err_accum
// Description : On-chip error characterisation of an approximate multiplier.
//               Streams (approx, exact) product pairs and accumulates the
//               error count, the sum of |approx - exact|, and the maximum
//               |approx - exact| over a programmed number of samples.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_err_accum #(
  parameter int P_W   = 64,
  parameter int CNT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P_W-1:0]       approx,
  input  logic [P_W-1:0]       exact,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [P_W+CNT_W-1:0] sum_ed,
  output logic [P_W-1:0]       max_ed
);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [P_W-1:0]   c_p_zero   = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_n_tgt;
  logic [CNT_W-1:0]       r_sample_cnt;
  logic                   r_in_ready;
  logic                   r_busy;
  logic                   r_done;

  logic                   r_s1_v;
  logic [P_W:0]           r_s1_diff;
  logic                   r_s2_v;
  logic [P_W-1:0]         r_s2_ed;
  logic                   r_s2_ne;

  logic [CNT_W-1:0]       r_err_cnt;
  logic [P_W+CNT_W-1:0]   r_sum_ed;
  logic [P_W-1:0]         r_max_ed;

  logic                   w_start_ok;
  logic                   w_xfer;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [P_W:0]           w_diff;
  logic [P_W-1:0]         w_ed;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer     = in_valid && r_in_ready;
  assign w_cnt_inc  = r_sample_cnt + c_cnt_one;

  // One extra bit keeps the signed difference exact for every input pair.
  assign w_diff = {approx[P_W-1], approx} - {exact[P_W-1], exact};

  // Negation modulo 2^P_W gives |diff| directly, since |diff| < 2^P_W.
  assign w_ed = r_s1_diff[P_W] ? (c_p_zero - r_s1_diff[P_W-1:0])
                               : r_s1_diff[P_W-1:0];

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n_tgt      <= c_cnt_zero;
      r_sample_cnt <= c_cnt_zero;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n_tgt      <= num_samples;
            r_sample_cnt <= c_cnt_zero;
            if (num_samples == c_cnt_zero) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_sample_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_n_tgt) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (!r_s1_v && !r_s2_v) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage difference / absolute-value pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_diff <= '0;
      r_s2_v    <= 1'b0;
      r_s2_ed   <= '0;
      r_s2_ne   <= 1'b0;
    end else begin
      r_s1_v <= w_xfer;
      if (w_xfer) begin
        r_s1_diff <= w_diff;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_ed <= w_ed;
        r_s2_ne <= |r_s1_diff;
      end
    end
  end

  // Statistics; a fresh start only happens with the pipeline already empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
    end else if (w_start_ok) begin
      r_err_cnt <= '0;
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
    end else if (r_s2_v) begin
      r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, r_s2_ne};
      r_sum_ed  <= r_sum_ed + {{CNT_W{1'b0}}, r_s2_ed};
      if (r_s2_ed > r_max_ed) begin
        r_max_ed <= r_s2_ed;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sum_ed     = r_sum_ed;
  assign max_ed     = r_max_ed;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_err_accum
// Description : Directed, table-driven self-checking bench for approx_err_accum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_err_accum;

  localparam int PW = 64;
  localparam int CW = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   num_samples;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   approx;
  logic [PW-1:0]   exact;
  logic            busy;
  logic            done;
  logic [CW-1:0]   sample_cnt;
  logic [CW-1:0]   err_cnt;
  logic [PW+CW-1:0] sum_ed;
  logic [PW-1:0]   max_ed;

  int n_tests = 0;
  int n_fail  = 0;

  approx_err_accum #(.P_W(PW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .approx      (approx),
    .exact       (exact),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]         num;
    logic [3:0][PW-1:0]    ap;
    logic [3:0][PW-1:0]    ex;
    logic [CW-1:0]         e_err;
    logic [PW+CW-1:0]      e_sum;
    logic [PW-1:0]         e_max;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start       = 1'b1;
    num_samples = n;
    step();
    start       = 1'b0;
  endtask

  task automatic send_pair(input logic [PW-1:0] a, input logic [PW-1:0] e, output bit ok);
    int w;
    in_valid = 1'b1;
    approx   = a;
    exact    = e;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    ok = (w < 20);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (!done && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    bit ok;
    int cyc;
    int k;
    bit xf;
    int pat [7] = '{1, 0, 1, 1, 0, 1, 1};

    // Vector table: {num, approx[], exact[], err, sum, max}
    vecs[0] = '0;
    vecs[0].num = 4;
    for (int i = 0; i < 4; i++) begin
      vecs[0].ap[i] = 64'h0000_0000_0000_1234;
      vecs[0].ex[i] = 64'h0000_0000_0000_1234;
    end
    vecs[0].e_err = 0; vecs[0].e_sum = 0; vecs[0].e_max = 0;

    vecs[1] = '0;
    vecs[1].num = 3;
    vecs[1].ap[0] = 64'd10;   vecs[1].ex[0] = 64'd7;
    vecs[1].ap[1] = -64'sd5;  vecs[1].ex[1] = 64'd3;
    vecs[1].ap[2] = -64'sd8;  vecs[1].ex[2] = -64'sd8;
    vecs[1].e_err = 2; vecs[1].e_sum = 84'd11; vecs[1].e_max = 64'd8;

    vecs[2] = '0;
    vecs[2].num = 1;
    vecs[2].ap[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    vecs[2].ex[0] = 64'h8000_0000_0000_0000;
    vecs[2].e_err = 1;
    vecs[2].e_sum = 84'h0_0000_FFFF_FFFF_FFFF_FFFF;
    vecs[2].e_max = 64'hFFFF_FFFF_FFFF_FFFF;

    // Negative extreme plus a small error: sum carries past bit 63.
    vecs[3] = '0;
    vecs[3].num = 2;
    vecs[3].ap[0] = 64'h8000_0000_0000_0000;
    vecs[3].ex[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    vecs[3].ap[1] = 64'd1;    vecs[3].ex[1] = -64'sd1;
    vecs[3].e_err = 2;
    vecs[3].e_sum = 84'h0_0001_0000_0000_0000_0001;
    vecs[3].e_max = 64'hFFFF_FFFF_FFFF_FFFF;

    rst = 1'b1; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; approx = '0; exact = '0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_sum_ed", sum_ed, 0);
    step();
    rst = 1'b0;
    step();

    // Reset mid-run after three transfers
    do_start(20'd8);
    for (int i = 0; i < 3; i++) begin
      send_pair(64'd5, 64'd1, ok);
      chk("mid_ready", ok, 1);
    end
    chk("mid_cnt_before", sample_cnt, 3);
    chk("mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sample_cnt", sample_cnt, 0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_sum_ed", sum_ed, 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("mid_idle_done", done, 0);
    chk("mid_idle_ready", in_ready, 0);

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      do_start(vecs[v].num);
      for (int i = 0; i < int'(vecs[v].num); i++) begin
        send_pair(vecs[v].ap[i], vecs[v].ex[i], ok);
        chk("vec_ready", ok, 1);
      end
      wait_done(8, cyc);
      chk("vec_done", done, 1);
      chk("vec_busy", busy, 0);
      chk("vec_sample_cnt", sample_cnt, vecs[v].num);
      chk("vec_err_cnt", err_cnt, vecs[v].e_err);
      chk("vec_sum_ed", sum_ed, vecs[v].e_sum);
      chk("vec_max_ed", max_ed, vecs[v].e_max);
    end

    // Handshake with gaps, drain latency, and an extra offered pair
    do_start(20'd5);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      if (pat[i] != 0) begin
        approx = 64'((k + 1) * 100);
        exact  = 64'((k + 1) * 100 - (k + 1));
      end else begin
        approx = 64'd999999;
        exact  = 64'd0;
      end
      xf = in_valid && in_ready;
      step();
      if (xf) begin
        k++;
        if (k == 5) chk("hs_ready_drop", in_ready, 0);
      end
    end
    chk("hs_xfers", k, 5);
    in_valid = 1'b1;
    approx   = -64'sd1000000;
    exact    = 64'd0;
    wait_done(3, cyc);
    chk("hs_done_lat", done, 1);
    step();
    in_valid = 1'b0;
    chk("hs_sample_cnt", sample_cnt, 5);
    chk("hs_err_cnt", err_cnt, 5);
    chk("hs_sum_ed", sum_ed, 15);
    chk("hs_max_ed", max_ed, 5);

    // Restart from DONE with zero samples
    do_start(20'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_sample_cnt", sample_cnt, 0);
    chk("z_err_cnt", err_cnt, 0);
    chk("z_sum_ed", sum_ed, 0);
    chk("z_max_ed", max_ed, 0);

    // start during RUN must be ignored
    do_start(20'd2);
    send_pair(64'd20, 64'd5, ok);
    chk("sr_ready1", ok, 1);
    do_start(20'd7);
    send_pair(64'd3, 64'd4, ok);
    chk("sr_ready2", ok, 1);
    wait_done(6, cyc);
    chk("sr_done", done, 1);
    chk("sr_sample_cnt", sample_cnt, 2);
    chk("sr_err_cnt", err_cnt, 2);
    chk("sr_sum_ed", sum_ed, 16);
    chk("sr_max_ed", max_ed, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
